// File: rtl/axi4_drop_resp_if.sv
// W/B/R handshake bundle between an AXI4 master and the drop-response terminator.
// The terminator never sees AW/AR or W data; the lookup FSM signals those with drop pulses.
interface axi4_drop_resp_if #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6
);
  logic                      wvalid;
  logic                      wlast;
  logic                      wready;
  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;
  logic [AXI_USER_WIDTH-1:0] buser;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ID_WIDTH-1:0]   rid;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic [AXI_USER_WIDTH-1:0] ruser;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output wvalid, wlast, bready, rready,
    input  wready, bid, bresp, buser, bvalid, rid, rdata, rresp, rlast, ruser, rvalid
  );

  modport slave (
    input  wvalid, wlast, bready, rready,
    output wready, bid, bresp, buser, bvalid, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi4_drop_resp.sv
// Terminates AXI4 transactions rejected by the RAB lookup: drains dropped writes and
// answers with one error B, answers dropped reads with len+1 zero-data error R beats.
module axi4_drop_resp #(
  parameter int         AXI_ID_WIDTH   = 4,
  parameter int         AXI_DATA_WIDTH = 64,
  parameter int         AXI_USER_WIDTH = 6,
  parameter logic [1:0] RESP_ERR       = 2'b10
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RI,
  input  logic                    wr_drop_i,
  input  logic [AXI_ID_WIDTH-1:0] wr_id_i,
  input  logic                    rd_drop_i,
  input  logic [AXI_ID_WIDTH-1:0] rd_id_i,
  input  logic [7:0]              rd_len_i,
  axi4_drop_resp_if.slave         s_axi4,
  output logic                    wr_busy_o,
  output logic                    rd_busy_o,
  output logic                    drop_lost_o
);

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_SEND}          r_state_e;

  w_state_e                w_state, w_next;
  r_state_e                r_state, r_next;
  logic [AXI_ID_WIDTH-1:0] bid_q, rid_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [7:0]              cnt_q;
  logic                    drop_lost_q;

  // Write channel: accept drop, swallow W beats up to wlast, then hold B until taken
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_drop_i) w_next = W_DRAIN;
      W_DRAIN: if (s_axi4.wvalid && s_axi4.wlast) w_next = W_RESP;
      W_RESP:  if (s_axi4.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      w_state <= W_IDLE;
      bid_q   <= '0;
      bresp_q <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && wr_drop_i) begin
        bid_q   <= wr_id_i;
        bresp_q <= RESP_ERR;
      end
    end
  end

  // Read channel: cnt holds the beats still owed after the current one
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_drop_i) r_next = R_SEND;
      R_SEND:  if (s_axi4.rready && cnt_q == 8'd0) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_state <= R_IDLE;
      rid_q   <= '0;
      rresp_q <= '0;
      cnt_q   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && rd_drop_i) begin
        rid_q   <= rd_id_i;
        rresp_q <= RESP_ERR;
        cnt_q   <= rd_len_i;
      end else if (r_state == R_SEND && s_axi4.rready && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // A drop that lands while its channel is busy is not served; flag it one cycle later
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      drop_lost_q <= 1'b0;
    end else begin
      drop_lost_q <= (wr_drop_i && w_state != W_IDLE) ||
                     (rd_drop_i && r_state != R_IDLE);
    end
  end

  assign s_axi4.wready = (w_state == W_DRAIN);
  assign s_axi4.bvalid = (w_state == W_RESP);
  assign s_axi4.bid    = bid_q;
  assign s_axi4.bresp  = bresp_q;
  assign s_axi4.buser  = '0;

  assign s_axi4.rvalid = (r_state == R_SEND);
  assign s_axi4.rlast  = (r_state == R_SEND) && (cnt_q == 8'd0);
  assign s_axi4.rid    = rid_q;
  assign s_axi4.rresp  = rresp_q;
  assign s_axi4.rdata  = '0;
  assign s_axi4.ruser  = '0;

  assign wr_busy_o   = (w_state != W_IDLE);
  assign rd_busy_o   = (r_state != R_IDLE);
  assign drop_lost_o = drop_lost_q;

endmodule

// File: tb/tb_axi4_drop_resp.sv
// Directed bench for axi4_drop_resp: expected B ids and R beats are queued when a
// drop is issued and popped as the DUT hands each response over.
module tb_axi4_drop_resp;

  localparam int         IDW  = 4;
  localparam int         DW   = 64;
  localparam int         UW   = 6;
  localparam logic [1:0] RERR = 2'b10;

  typedef struct {
    logic [IDW-1:0] id;
    logic           last;
  } r_exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_drop, rd_drop;
  logic [IDW-1:0] wr_id, rd_id;
  logic [7:0]     rd_len;
  logic           wr_busy, rd_busy, drop_lost;

  axi4_drop_resp_if #(.AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)) bus ();

  axi4_drop_resp #(
    .AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .RESP_ERR(RERR)
  ) dut (
    .Clk_CI      (clk),
    .Rst_RI      (rst),
    .wr_drop_i   (wr_drop),
    .wr_id_i     (wr_id),
    .rd_drop_i   (rd_drop),
    .rd_id_i     (rd_id),
    .rd_len_i    (rd_len),
    .s_axi4      (bus.slave),
    .wr_busy_o   (wr_busy),
    .rd_busy_o   (rd_busy),
    .drop_lost_o (drop_lost)
  );

  always #5 clk = ~clk;

  int             n_cmp = 0;
  int             n_err = 0;
  int             r_beats;
  int             w_taken;
  r_exp_t         rq[$];
  logic [IDW-1:0] bq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [IDW-1:0] id, input int len);
    for (int i = 0; i <= len; i++) begin
      r_exp_t e;
      e.id   = id;
      e.last = (i == len);
      rq.push_back(e);
    end
  endtask

  task automatic send_w(input int nbeats, input int max_cyc);
    int cyc = 0;
    int i   = 0;
    while (i < nbeats && cyc < max_cyc) begin
      bus.wvalid = 1'b1;
      bus.wlast  = (i == nbeats - 1);
      if (bus.wready) begin
        i++;
        w_taken++;
      end
      tick();
      cyc++;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    chk("w_beats_taken", 64'(i), 64'(nbeats));
  endtask

  task automatic recv_b(input int stall, input int max_cyc);
    int cyc = 0;
    bus.bready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("b_stall_valid", 64'(bus.bvalid), 64'(1));
      chk("b_stall_id", 64'(bus.bid), 64'(bq[0]));
      chk("b_stall_resp", 64'(bus.bresp), 64'(RERR));
      chk("b_stall_busy", 64'(wr_busy), 64'(1));
      tick();
    end
    bus.bready = 1'b1;
    while (!bus.bvalid && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    chk("b_valid_seen", 64'(bus.bvalid), 64'(1));
    if (bus.bvalid) begin
      logic [IDW-1:0] eid;
      eid = bq.pop_front();
      chk("b_id", 64'(bus.bid), 64'(eid));
      chk("b_resp", 64'(bus.bresp), 64'(RERR));
      chk("b_user", 64'(bus.buser), 64'(0));
      tick();
      bus.bready = 1'b0;
      chk("b_valid_after", 64'(bus.bvalid), 64'(0));
      chk("wr_busy_after", 64'(wr_busy), 64'(0));
    end
    bus.bready = 1'b0;
  endtask

  task automatic recv_r(input int max_cyc, input bit rnd, input int max_beats);
    int             cyc   = 0;
    int             beats = 0;
    bit             stall = 1'b0;
    logic [IDW-1:0] s_id  = '0;
    logic           s_last = 1'b0;
    logic [1:0]     s_resp = '0;
    r_exp_t         e;
    while (rq.size() > 0 && cyc < max_cyc && (max_beats == 0 || beats < max_beats)) begin
      if (stall) begin
        chk("r_stall_valid", 64'(bus.rvalid), 64'(1));
        chk("r_stall_id", 64'(bus.rid), 64'(s_id));
        chk("r_stall_last", 64'(bus.rlast), 64'(s_last));
        chk("r_stall_resp", 64'(bus.rresp), 64'(s_resp));
      end
      bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = 1'b0;
      if (bus.rvalid && bus.rready) begin
        e = rq.pop_front();
        chk("r_id", 64'(bus.rid), 64'(e.id));
        chk("r_last", 64'(bus.rlast), 64'(e.last));
        chk("r_resp", 64'(bus.rresp), 64'(RERR));
        chk("r_data", bus.rdata, 64'(0));
        chk("r_user", 64'(bus.ruser), 64'(0));
        beats++;
        r_beats++;
      end else if (bus.rvalid) begin
        stall  = 1'b1;
        s_id   = bus.rid;
        s_last = bus.rlast;
        s_resp = bus.rresp;
      end
      tick();
      cyc++;
    end
    bus.rready = 1'b0;
    if (max_beats == 0) chk("r_all_received", 64'(rq.size()), 64'(0));
  endtask

  initial begin
    rst        = 1'b1;
    wr_drop    = 1'b0;
    rd_drop    = 1'b0;
    wr_id      = '0;
    rd_id      = '0;
    rd_len     = '0;
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_wready", 64'(bus.wready), 64'(0));
    chk("rst_bvalid", 64'(bus.bvalid), 64'(0));
    chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
    chk("rst_rlast", 64'(bus.rlast), 64'(0));
    chk("rst_bid", 64'(bus.bid), 64'(0));
    chk("rst_bresp", 64'(bus.bresp), 64'(0));
    chk("rst_rid", 64'(bus.rid), 64'(0));
    chk("rst_rresp", 64'(bus.rresp), 64'(0));
    chk("rst_wr_busy", 64'(wr_busy), 64'(0));
    chk("rst_rd_busy", 64'(rd_busy), 64'(0));
    chk("rst_drop_lost", 64'(drop_lost), 64'(0));

    // Write id=3, 4 beats; a stray wvalid before the drop must not be taken
    bus.wvalid = 1'b1;
    wr_drop = 1'b1;
    wr_id   = 4'd3;
    bq.push_back(4'd3);
    chk("w_idle_wready", 64'(bus.wready), 64'(0));
    tick();
    wr_drop = 1'b0;
    chk("w_drain_wready", 64'(bus.wready), 64'(1));
    chk("w_busy", 64'(wr_busy), 64'(1));
    chk("w_no_lost", 64'(drop_lost), 64'(0));
    w_taken = 0;
    send_w(4, 20);
    chk("w_resp_wready", 64'(bus.wready), 64'(0));
    chk("w_resp_bvalid", 64'(bus.bvalid), 64'(1));
    recv_b(0, 10);

    // Single-beat write at minimum latency, then B held off for 10 cycles
    wr_drop = 1'b1;
    wr_id   = 4'd9;
    bq.push_back(4'd9);
    tick();
    wr_drop    = 1'b0;
    bus.wvalid = 1'b1;
    bus.wlast  = 1'b1;
    chk("w1_wready_n1", 64'(bus.wready), 64'(1));
    tick();
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    chk("w1_bvalid_n2", 64'(bus.bvalid), 64'(1));
    recv_b(10, 10);

    // Single-beat read id=5
    rd_drop = 1'b1;
    rd_id   = 4'd5;
    rd_len  = 8'd0;
    push_rd(4'd5, 0);
    tick();
    rd_drop = 1'b0;
    chk("r0_rvalid_n1", 64'(bus.rvalid), 64'(1));
    recv_r(20, 1'b0, 0);
    chk("r0_rd_busy_after", 64'(rd_busy), 64'(0));

    // 256-beat read with random backpressure
    rd_drop = 1'b1;
    rd_id   = 4'hA;
    rd_len  = 8'd255;
    push_rd(4'hA, 255);
    tick();
    rd_drop = 1'b0;
    r_beats = 0;
    recv_r(3000, 1'b1, 0);
    chk("r256_beat_count", 64'(r_beats), 64'(256));
    chk("r256_rd_busy_after", 64'(rd_busy), 64'(0));

    // Second read drop while busy is lost and leaves the first burst intact
    rd_drop = 1'b1;
    rd_id   = 4'd2;
    rd_len  = 8'd3;
    push_rd(4'd2, 3);
    tick();
    rd_id  = 4'd7;
    rd_len = 8'd0;
    tick();
    rd_drop = 1'b0;
    chk("lost_pulse", 64'(drop_lost), 64'(1));
    chk("lost_rid_kept", 64'(bus.rid), 64'(2));
    tick();
    chk("lost_pulse_end", 64'(drop_lost), 64'(0));
    r_beats = 0;
    recv_r(40, 1'b0, 0);
    chk("lost_burst_beats", 64'(r_beats), 64'(4));
    chk("lost_rvalid_after", 64'(bus.rvalid), 64'(0));

    // Simultaneous write and read drops
    wr_drop = 1'b1;
    wr_id   = 4'd1;
    rd_drop = 1'b1;
    rd_id   = 4'hE;
    rd_len  = 8'd1;
    bq.push_back(4'd1);
    push_rd(4'hE, 1);
    tick();
    wr_drop = 1'b0;
    rd_drop = 1'b0;
    chk("sim_wr_busy", 64'(wr_busy), 64'(1));
    chk("sim_rd_busy", 64'(rd_busy), 64'(1));
    chk("sim_no_lost", 64'(drop_lost), 64'(0));
    recv_r(20, 1'b0, 0);
    send_w(2, 20);
    recv_b(0, 10);

    // Reset during beat 3 of an 8-beat read, then a clean 2-beat read
    rd_drop = 1'b1;
    rd_id   = 4'd4;
    rd_len  = 8'd7;
    push_rd(4'd4, 7);
    tick();
    rd_drop = 1'b0;
    recv_r(20, 1'b0, 3);
    chk("rst_mid_rvalid_before", 64'(bus.rvalid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_rvalid", 64'(bus.rvalid), 64'(0));
    chk("rst_mid_rlast", 64'(bus.rlast), 64'(0));
    chk("rst_mid_rd_busy", 64'(rd_busy), 64'(0));
    chk("rst_mid_rid", 64'(bus.rid), 64'(0));
    rq.delete();
    rd_drop = 1'b1;
    rd_id   = 4'd6;
    rd_len  = 8'd1;
    push_rd(4'd6, 1);
    tick();
    rd_drop = 1'b0;
    r_beats = 0;
    recv_r(20, 1'b0, 0);
    chk("post_rst_beats", 64'(r_beats), 64'(2));
    chk("post_rst_rd_busy", 64'(rd_busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
